// File: rtl/freq_counter_pkg.sv
// freq_counter_pkg: state encoding and default sizing shared by the
// frequency-counter stages (synchronizer, gate counter, display).
package freq_counter_pkg;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
    localparam int unsigned DEF_CNT_W       = 32;

endpackage

// File: rtl/freq_gate_counter_if.sv
// freq_gate_counter_if: measured-signal/control inputs and published result
// of the gate counter; master drives the inputs, slave is the counter.
interface freq_gate_counter_if
    import freq_counter_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             sync_signal;
    logic             enable;
    logic [CNT_W-1:0] freq_count;
    logic             freq_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output sync_signal, enable,
        input  freq_count, freq_valid, overflow, busy
    );

    modport slave (
        input  sync_signal, enable,
        output freq_count, freq_valid, overflow, busy
    );

endinterface

// File: rtl/freq_gate_counter_edge.sv
// rising_edge_detect: one-cycle pulse on a 0->1 transition of a signal that
// is already in the clock domain; history flop runs in every state.
module rising_edge_detect (
    input  logic clock,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= sig;
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of sync_signal over fixed windows of
// GATE_CYCLES clocks and publishes each window's count with a valid strobe.
module freq_gate_counter
    import freq_counter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input logic               clock,
    input logic               rst_n,
    freq_gate_counter_if.slave bus
);

    localparam int unsigned   GW   = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    state_e           state_q;
    logic [GW-1:0]    gate_cnt_q;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, res_cnt_q, freq_count_q;
    logic             ovf_q, ovf_d, res_ovf_q, res_pend_q;
    logic             overflow_q, freq_valid_q, busy_q;
    logic             rise, term, sat;

    rising_edge_detect u_edge (
        .clock (clock),
        .rst_n (rst_n),
        .sig   (bus.sync_signal),
        .rise  (rise)
    );

    always_comb begin
        sat        = &edge_cnt_q;
        term       = (state_q == MEASURE) && (gate_cnt_q == LAST);
        edge_cnt_d = (rise && !sat) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
        ovf_d      = ovf_q | (rise & sat);
    end

    // Window results are staged one cycle so freq_count, overflow and
    // freq_valid all change together on the cycle after the terminal cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            res_cnt_q    <= '0;
            res_ovf_q    <= 1'b0;
            res_pend_q   <= 1'b0;
            freq_count_q <= '0;
            overflow_q   <= 1'b0;
            freq_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            freq_valid_q <= res_pend_q;
            res_pend_q   <= 1'b0;
            if (res_pend_q) begin
                freq_count_q <= res_cnt_q;
                overflow_q   <= res_ovf_q;
            end
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        state_q <= MEASURE;
                        busy_q  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (term) begin
                        res_cnt_q  <= edge_cnt_d;
                        res_ovf_q  <= ovf_d;
                        res_pend_q <= 1'b1;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        ovf_q      <= 1'b0;
                        if (!bus.enable) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (!bus.enable) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        ovf_q      <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GW'(1);
                        edge_cnt_q <= edge_cnt_d;
                        ovf_q      <= ovf_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.freq_count = freq_count_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: drives a 32-bit and a 4-bit counter with identical
// stimulus and checks both against per-window edge counts of the stimulus.
module tb_freq_gate_counter;

    localparam int G = 100;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic sig   = 1'b0;
    logic en    = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] last32 = '0;

    always #5 clock = ~clock;

    freq_gate_counter_if #(.CNT_W(32)) b32 ();
    freq_gate_counter_if #(.CNT_W(4))  b4 ();

    assign b32.sync_signal = sig;
    assign b32.enable      = en;
    assign b4.sync_signal  = sig;
    assign b4.enable       = en;

    freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(32)) dut32 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (b32.slave)
    );

    freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs n back-to-back windows from IDLE; expected counts are the number of
    // 0->1 transitions of the stimulus sampled inside each window.
    task automatic measure(input int n, input int mode, output int sum_rep, output int total);
        bit s[];
        int raw[];
        int w, e4;
        logic exp_v, exp_b;
        s   = new[n*G+2];
        raw = new[n];
        for (int t = 0; t < n*G+2; t++) begin
            case (mode)
                0:       s[t] = bit'(t % 2);
                1:       s[t] = bit'((t / 5) % 2);
                2:       s[t] = (t >= G && t < G+50) || (t >= 2*G+1);
                3:       s[t] = (t <= G) ? bit'(t % 2) : bit'((t / 5) % 2);
                default: s[t] = bit'($urandom_range(0, 1));
            endcase
        end
        total   = 0;
        sum_rep = 0;
        for (int k = 0; k < n; k++) begin
            raw[k] = 0;
            for (int t = k*G+1; t <= (k+1)*G; t++)
                if (s[t] && !s[t-1]) raw[k]++;
            total += raw[k];
        end
        sig = s[0];
        en  = 1'b1;
        step();
        checks++;
        if (b32.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_start: got %b want 1", b32.busy);
        end
        for (int t = 1; t <= n*G+1; t++) begin
            sig = s[t];
            if (t == n*G) en = 1'b0;
            step();
            exp_v = (t > 1) && ((t - 1) % G == 0);
            exp_b = (t < n*G);
            checks++;
            if (b32.freq_valid !== exp_v || b4.freq_valid !== exp_v) begin
                failures++;
                $display("FAIL valid t=%0d: got %b/%b want %b", t, b32.freq_valid, b4.freq_valid, exp_v);
            end
            checks++;
            if (b32.busy !== exp_b) begin
                failures++;
                $display("FAIL busy t=%0d: got %b want %b", t, b32.busy, exp_b);
            end
            if (exp_v) begin
                w  = (t - 2) / G;
                e4 = (raw[w] > 15) ? 15 : raw[w];
                checks++;
                if (b32.freq_count !== 32'(raw[w]) || b32.overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL count32 win=%0d: got %0d ovf=%b want %0d ovf=0", w, b32.freq_count, b32.overflow, raw[w]);
                end
                checks++;
                if (b4.freq_count !== 4'(e4) || b4.overflow !== (raw[w] > 15)) begin
                    failures++;
                    $display("FAIL count4 win=%0d: got %0d ovf=%b want %0d ovf=%b", w, b4.freq_count, b4.overflow, e4, raw[w] > 15);
                end
                sum_rep += int'(b32.freq_count);
                last32 = 32'(raw[w]);
            end
        end
    endtask

    task automatic test_reset();
        int sr, tot;
        repeat (3) step();
        checks++;
        if (b32.freq_count !== '0 || b32.freq_valid !== 1'b0 || b32.overflow !== 1'b0 || b32.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: cnt=%0d v=%b o=%b b=%b want all 0", b32.freq_count, b32.freq_valid, b32.overflow, b32.busy);
        end
        rst_n = 1'b1;
        step();
        measure(1, 0, sr, tot);
        en = 1'b1;
        repeat (60) begin
            sig = ~sig;
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (b32.freq_count !== '0 || b32.freq_valid !== 1'b0 || b32.overflow !== 1'b0 || b32.busy !== 1'b0 ||
            b4.freq_count !== '0 || b4.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: cnt=%0d v=%b o=%b b=%b cnt4=%0d o4=%b want all 0",
                     b32.freq_count, b32.freq_valid, b32.overflow, b32.busy, b4.freq_count, b4.overflow);
        end
        en = 1'b0;
        step();
        rst_n = 1'b1;
        last32 = '0;
        for (int t = 0; t < 300; t++) begin
            sig = bit'($urandom_range(0, 1));
            step();
            checks++;
            if (b32.freq_valid !== 1'b0 || b32.busy !== 1'b0 || b32.freq_count !== '0) begin
                failures++;
                $display("FAIL idle_hold t=%0d: v=%b b=%b cnt=%0d want 0 0 0", t, b32.freq_valid, b32.busy, b32.freq_count);
            end
        end
    endtask

    task automatic test_toggle();
        int sr, tot;
        measure(3, 0, sr, tot);
        checks++;
        if (sr !== 150) begin
            failures++;
            $display("FAIL toggle_sum: got %0d want 150", sr);
        end
    endtask

    task automatic test_back_to_back();
        int sr, tot;
        measure(5, 1, sr, tot);
        checks++;
        if (sr !== tot || tot !== 50) begin
            failures++;
            $display("FAIL b2b_sum: reported %0d stimulus %0d want 50", sr, tot);
        end
    endtask

    task automatic test_boundary();
        int sr, tot;
        measure(3, 2, sr, tot);
        checks++;
        if (sr !== 2) begin
            failures++;
            $display("FAIL boundary_sum: got %0d want 2", sr);
        end
    endtask

    task automatic test_abort();
        int sr, tot;
        measure(1, 1, sr, tot);
        en = 1'b1;
        step();
        for (int t = 1; t <= 120; t++) begin
            sig = bit'((t / 5) % 2);
            if (t == 50) en = 1'b0;
            step();
            checks++;
            if (b32.freq_valid !== 1'b0 || b32.freq_count !== 32'd10 || b32.busy !== (t < 50)) begin
                failures++;
                $display("FAIL abort t=%0d: v=%b cnt=%0d b=%b want 0 10 %b", t, b32.freq_valid, b32.freq_count, b32.busy, t < 50);
            end
        end
        measure(1, 1, sr, tot);
        checks++;
        if (sr !== 10) begin
            failures++;
            $display("FAIL abort_reenable: got %0d want 10", sr);
        end
    endtask

    task automatic test_saturate();
        int sr, tot;
        measure(2, 3, sr, tot);
        checks++;
        if (b4.freq_count !== 4'd10 || b4.overflow !== 1'b0) begin
            failures++;
            $display("FAIL sat_recover: got %0d ovf=%b want 10 ovf=0", b4.freq_count, b4.overflow);
        end
    endtask

    task automatic test_random();
        int sr, tot;
        for (int r = 0; r < 4; r++) begin
            measure(2, 4, sr, tot);
            repeat ($urandom_range(0, 5)) step();
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_back_to_back();
        test_boundary();
        test_abort();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
